// File: rtl/act_pkg.sv
// Shared types, Q2.14 constants and tanh scaling helpers for the activation scheduler.
package act_pkg;

   localparam logic FUNC_SIG  = 1'b0;
   localparam logic FUNC_TANH = 1'b1;

   localparam logic signed [15:0] Q_ONE     = 16'sh4000;
   localparam logic signed [15:0] Q_NEG_ONE = 16'shC000;
   localparam logic signed [15:0] Q_MAX     = 16'sh7FFF;
   localparam logic signed [15:0] Q_MIN     = 16'sh8000;

   // Wide enough for up to 16 requesters.
   localparam int unsigned ID_W = 4;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            func;
   } tag_t;

   // tanh pre-scale: 2x in 17 bits, saturated back into Q2.14.
   function automatic logic [15:0] tanh_pre(input logic [15:0] x);
      logic [16:0] d;
      d = {x, 1'b0};
      if (d[16] != d[15]) begin
         return d[16] ? Q_MIN : Q_MAX;
      end
      return d[15:0];
   endfunction

   // tanh post-scale: 2r - 1 in 17 bits, clamped to [-1, +1].
   function automatic logic [15:0] tanh_post(input logic [15:0] r);
      logic signed [16:0] d;
      d = $signed({r, 1'b0}) - $signed({Q_ONE[15], Q_ONE});
      if (d > $signed({Q_ONE[15], Q_ONE})) begin
         return Q_ONE;
      end else if (d < $signed({Q_NEG_ONE[15], Q_NEG_ONE})) begin
         return Q_NEG_ONE;
      end
      return d[15:0];
   endfunction

endpackage

// File: rtl/act_scheduler_if.sv
// Requester-side bus of the activation scheduler: requests, grants and routed results.
interface act_scheduler_if #(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned LAT   = 4,
   parameter int unsigned W     = 16
) ();

   localparam int unsigned IW = $clog2(LAT + 3);

   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   req_func;
   logic [N_REQ*W-1:0] req_data;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   rsp_valid;
   logic [W-1:0]       rsp_data;
   logic [IW-1:0]      inflight;
   logic               err;

   modport master (
      output req, req_func, req_data,
      input  gnt, rsp_valid, rsp_data, inflight, err
   );

   modport slave (
      input  req, req_func, req_data,
      output gnt, rsp_valid, rsp_data, inflight, err
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered rotating pointer.
module rr_arbiter #(
   parameter int unsigned N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   // Pick the first request at or after ptr; the second pass handles wrap-around.
   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i] && (PW'(i) >= ptr_q)) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = (i == int'(N) - 1) ? '0 : PW'(i + 1);
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req[i]) begin
            found  = 1'b1;
            gnt[i] = 1'b1;
            ptr_d  = (i == int'(N) - 1) ? '0 : PW'(i + 1);
         end
      end
   end

   // Pointer register; holds when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/sigmoid.sv
// Pipelined piecewise-linear sigmoid core, Q2.14 in and out, fixed LAT-cycle latency.
module sigmoid #(
   parameter int unsigned LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [15:0] x,
   output logic [15:0] result,
   output logic        result_valid
);

   logic [LAT-1:0][15:0] data_q, data_d;
   logic [LAT-1:0]       vld_q, vld_d;

   // Slopes 1/4 below |x|=1 and 1/8 above; negative inputs use 1 - f(|x|).
   function automatic logic [15:0] sig_approx(input logic [15:0] xv);
      logic [16:0] a;
      logic [15:0] f;
      a = xv[15] ? (17'd0 - {1'b1, xv}) : {1'b0, xv};
      if (a < 17'd16384) begin
         f = 16'(a >> 2) + 16'h2000;
      end else begin
         f = 16'(a >> 3) + 16'h2800;
      end
      return xv[15] ? (16'h4000 - f) : f;
   endfunction

   // Evaluate on entry, then shift through the remaining stages.
   always_comb begin
      data_d    = data_q;
      vld_d     = vld_q;
      data_d[0] = en ? sig_approx(x) : '0;
      vld_d[0]  = en;
      for (int k = 1; k < int'(LAT); k++) begin
         data_d[k] = data_q[k-1];
         vld_d[k]  = vld_q[k-1];
      end
   end

   // Pipeline registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         vld_q  <= '0;
      end else begin
         data_q <= data_d;
         vld_q  <= vld_d;
      end
   end

   assign result       = data_q[LAT-1];
   assign result_valid = vld_q[LAT-1];

endmodule

// File: rtl/act_scheduler.sv
// Shares one sigmoid core among N_REQ requesters; tanh runs as 2*sig(2x)-1 on the same core.
module act_scheduler
   import act_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   parameter int unsigned LAT   = 4,
   parameter int unsigned W     = 16
) (
   input logic            clk,
   input logic            rst,
   act_scheduler_if.slave bus
);

   localparam int unsigned IW = $clog2(LAT + 3);

   logic [N_REQ-1:0] gnt;
   logic             grant_valid;
   logic [ID_W-1:0]  grant_id;
   logic             grant_func;
   logic [W-1:0]     grant_data;

   logic             issue_valid_q, issue_valid_d;
   logic [ID_W-1:0]  issue_id_q, issue_id_d;
   logic             issue_func_q, issue_func_d;
   logic [W-1:0]     issue_data_q, issue_data_d;

   tag_t [LAT-1:0]   tag_q, tag_d;
   tag_t             tail;

   logic             core_rst_n;
   logic [W-1:0]     core_result;
   logic             core_rvalid;

   logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [W-1:0]     rsp_data_q, rsp_data_d;
   logic [IW-1:0]    inflight_q, inflight_d;
   logic             err_q, err_d;

   rr_arbiter #(
      .N(N_REQ)
   ) u_arb (
      .clk(clk),
      .rst(rst),
      .req(bus.req),
      .gnt(gnt)
   );

   // Encode the one-hot grant and select the winner's operand and function.
   always_comb begin
      grant_valid = |gnt;
      grant_id    = '0;
      grant_func  = FUNC_SIG;
      grant_data  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (gnt[i]) begin
            grant_id   = ID_W'(i);
            grant_func = bus.req_func[i];
            grant_data = bus.req_data[i*W +: W];
         end
      end
   end

   // Issue stage: capture on grant, pre-scaling tanh operands.
   always_comb begin
      issue_valid_d = grant_valid;
      issue_id_d    = issue_id_q;
      issue_func_d  = issue_func_q;
      issue_data_d  = issue_data_q;
      if (grant_valid) begin
         issue_id_d   = grant_id;
         issue_func_d = grant_func;
         issue_data_d = (grant_func == FUNC_TANH) ? tanh_pre(grant_data) : grant_data;
      end
   end

   assign core_rst_n = ~rst;

   sigmoid #(
      .LAT(LAT)
   ) u_core (
      .clk         (clk),
      .rst_n       (core_rst_n),
      .en          (issue_valid_q),
      .x           (issue_data_q),
      .result      (core_result),
      .result_valid(core_rvalid)
   );

   // Tag pipeline advancing in lockstep with the core.
   always_comb begin
      tag_d    = tag_q;
      tag_d[0] = tag_t'{valid: issue_valid_q, id: issue_id_q, func: issue_func_q};
      for (int k = 1; k < int'(LAT); k++) begin
         tag_d[k] = tag_q[k-1];
      end
      tail = tag_q[LAT-1];
   end

   // Return stage follows the tail tag; err latches any tag/core valid disagreement.
   always_comb begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (tail.valid) begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (tail.id == ID_W'(i)) begin
               rsp_valid_d[i] = 1'b1;
            end
         end
         rsp_data_d = (tail.func == FUNC_SIG) ? core_result : tanh_post(core_result);
      end
      err_d      = err_q | (core_rvalid ^ tail.valid);
      inflight_d = inflight_q + IW'(grant_valid) - IW'(|rsp_valid_q);
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_valid_q <= 1'b0;
         issue_id_q    <= '0;
         issue_func_q  <= FUNC_SIG;
         issue_data_q  <= '0;
         tag_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
         inflight_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         issue_valid_q <= issue_valid_d;
         issue_id_q    <= issue_id_d;
         issue_func_q  <= issue_func_d;
         issue_data_q  <= issue_data_d;
         tag_q         <= tag_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         inflight_q    <= inflight_d;
         err_q         <= err_d;
      end
   end

   assign bus.gnt       = gnt;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.inflight  = inflight_q;
   assign bus.err       = err_q;

endmodule
